// File: rtl/r5fp_unpack_pkg.sv
// Shared R5FP front-end definitions: status word layout and exponent range helpers.
package r5fp_unpack_pkg;

  localparam int unsigned StatusW     = 6;
  localparam int unsigned StatIsZero  = 0;
  localparam int unsigned StatIsInf   = 1;
  localparam int unsigned StatIsNan   = 2;
  localparam int unsigned StatInvalid = 3;
  localparam int unsigned StatSticky  = 4;
  localparam int unsigned StatSign    = 5;

  // Internal exponent of the largest denormal; also the rebias offset.
  function automatic int unsigned exp_denormal_max(input int unsigned exp_w);
    return 32'd1 << (exp_w - 32'd2);
  endfunction

  function automatic int unsigned exp_denormal_min(input int unsigned exp_w,
                                                   input int unsigned sig_w);
    return exp_denormal_max(exp_w) - (sig_w - 32'd1);
  endfunction

  function automatic int unsigned exp_normal_max(input int unsigned exp_w);
    return exp_denormal_max(exp_w) + (32'd1 << (exp_w - 32'd1)) - 32'd2;
  endfunction

endpackage

// File: rtl/r5fp_unpack_classify.sv
// Combinational field split and classification of a packed IEEE-754 operand.
// Produces the final unpacked fields for every class except denormals.
module r5fp_unpack_classify
  import r5fp_unpack_pkg::*;
#(
  parameter int unsigned SigW = 23,
  parameter int unsigned ExpW = 9
) (
  input  logic [SigW+ExpW-1:0] a_i,
  output logic                 sign_o,
  output logic [SigW-1:0]      frac_o,
  output logic                 is_denorm_o,
  output logic [ExpW-1:0]      exp_o,
  output logic [SigW+1:0]      sig_o,
  output logic [StatusW-1:0]   status_o
);

  localparam int unsigned FieldW = ExpW - 1;
  localparam logic [ExpW-1:0] Bias = ExpW'(exp_denormal_max(ExpW));

  logic [FieldW-1:0] field_exp;
  logic              exp_zero;
  logic              exp_ones;
  logic              frac_zero;
  logic              is_zero;
  logic              is_inf;
  logic              is_nan;

  assign sign_o      = a_i[SigW+ExpW-1];
  assign field_exp   = a_i[SigW +: FieldW];
  assign frac_o      = a_i[SigW-1:0];
  assign exp_zero    = (field_exp == '0);
  assign exp_ones    = &field_exp;
  assign frac_zero   = (frac_o == '0);
  assign is_zero     = exp_zero & frac_zero;
  assign is_inf      = exp_ones & frac_zero;
  assign is_nan      = exp_ones & ~frac_zero;
  assign is_denorm_o = exp_zero & ~frac_zero;

  always_comb begin
    exp_o    = {1'b0, field_exp} + Bias;
    sig_o    = {2'b01, frac_o};
    status_o = '0;
    if (is_zero) begin
      exp_o = '0;
      sig_o = '0;
    end else if (is_inf) begin
      exp_o = '1;
      sig_o = '0;
    end else if (is_nan) begin
      exp_o = '1;
    end
    status_o[StatIsZero]  = is_zero;
    status_o[StatIsInf]   = is_inf;
    status_o[StatIsNan]   = is_nan;
    // Quiet bit clear marks a signaling NaN.
    status_o[StatInvalid] = is_nan & ~frac_o[SigW-1];
    status_o[StatSticky]  = 1'b0;
    status_o[StatSign]    = sign_o;
  end

endmodule

// File: rtl/r5fp_unpack.sv
// Sequential IEEE-754 unpacker: classifies on accept, normalizes denormals one bit
// per cycle, and presents the result through a single-entry valid/ready register.
module r5fp_unpack
  import r5fp_unpack_pkg::*;
#(
  parameter  int unsigned SIG_W   = 23,
  parameter  int unsigned EXP_W   = 9,
  localparam int unsigned I_SIG_W = SIG_W + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIG_W+EXP_W-1:0] a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   aSign,
  output logic [EXP_W-1:0]       aExp,
  output logic [I_SIG_W-1:0]     aSig,
  output logic [StatusW-1:0]     aStatus
);

  localparam logic [EXP_W-1:0] ExpDenormMax = EXP_W'(exp_denormal_max(EXP_W));
  localparam logic [EXP_W-1:0] ExpDenormMin = EXP_W'(exp_denormal_min(EXP_W, SIG_W));

  typedef enum logic [0:0] {StIdle, StNorm} state_e;

  state_e               state_q, state_d;
  logic [SIG_W-1:0]     work_frac_q, work_frac_d;
  logic [EXP_W-1:0]     work_exp_q, work_exp_d;
  logic                 work_sign_q, work_sign_d;
  logic                 out_valid_q, out_valid_d;
  logic                 a_sign_q, a_sign_d;
  logic [EXP_W-1:0]     a_exp_q, a_exp_d;
  logic [I_SIG_W-1:0]   a_sig_q, a_sig_d;
  logic [StatusW-1:0]   a_status_q, a_status_d;

  logic                 cls_sign;
  logic [SIG_W-1:0]     cls_frac;
  logic                 cls_denorm;
  logic [EXP_W-1:0]     cls_exp;
  logic [I_SIG_W-1:0]   cls_sig;
  logic [StatusW-1:0]   cls_status;
  logic                 slot_free;

  r5fp_unpack_classify #(
    .SigW(SIG_W),
    .ExpW(EXP_W)
  ) u_classify (
    .a_i        (a),
    .sign_o     (cls_sign),
    .frac_o     (cls_frac),
    .is_denorm_o(cls_denorm),
    .exp_o      (cls_exp),
    .sig_o      (cls_sig),
    .status_o   (cls_status)
  );

  assign slot_free = ~out_valid_q | out_ready;

  always_comb begin
    state_d     = state_q;
    work_frac_d = work_frac_q;
    work_exp_d  = work_exp_q;
    work_sign_d = work_sign_q;
    out_valid_d = out_valid_q & ~out_ready;
    a_sign_d    = a_sign_q;
    a_exp_d     = a_exp_q;
    a_sig_d     = a_sig_q;
    a_status_d  = a_status_q;
    in_ready    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          if (cls_denorm) begin
            work_frac_d = cls_frac;
            work_exp_d  = ExpDenormMax;
            work_sign_d = cls_sign;
            state_d     = StNorm;
          end else begin
            out_valid_d = 1'b1;
            a_sign_d    = cls_sign;
            a_exp_d     = cls_exp;
            a_sig_d     = cls_sig;
            a_status_d  = cls_status;
          end
        end
      end
      StNorm: begin
        if (!work_frac_q[SIG_W-1]) begin
          work_frac_d = work_frac_q << 1;
          work_exp_d  = work_exp_q - EXP_W'(1);
        end else if (slot_free) begin
          // The leading one becomes the implicit bit; the rest shifts up one place.
          out_valid_d          = 1'b1;
          a_sign_d             = work_sign_q;
          a_exp_d              = work_exp_q;
          a_sig_d              = {2'b01, work_frac_q[SIG_W-2:0], 1'b0};
          a_status_d           = '0;
          a_status_d[StatSign] = work_sign_q;
          state_d              = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      work_frac_q <= '0;
      work_exp_q  <= '0;
      work_sign_q <= 1'b0;
      out_valid_q <= 1'b0;
      a_sign_q    <= 1'b0;
      a_exp_q     <= '0;
      a_sig_q     <= '0;
      a_status_q  <= '0;
    end else begin
      state_q     <= state_d;
      work_frac_q <= work_frac_d;
      work_exp_q  <= work_exp_d;
      work_sign_q <= work_sign_d;
      out_valid_q <= out_valid_d;
      a_sign_q    <= a_sign_d;
      a_exp_q     <= a_exp_d;
      a_sig_q     <= a_sig_d;
      a_status_q  <= a_status_d;
    end
  end

  assign out_valid = out_valid_q;
  assign aSign     = a_sign_q;
  assign aExp      = a_exp_q;
  assign aSig      = a_sig_q;
  assign aStatus   = a_status_q;

  // A nonzero fraction reaches its leading one before the exponent leaves the denormal range.
  norm_exp_in_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == StNorm && work_frac_q[SIG_W-1]) |-> (work_exp_q >= ExpDenormMin));

endmodule
